tristate_activity_monitor: RTL and testbench

- Consumer stage placed directly downstream of the tristate driver. Samples its data output and high-Z indicator every clock.
- Accumulates switching-activity statistics over fixed windows of WINDOW cycles: toggles, Z cycles and Z entry/exit transitions.
- Presents each window's result on a valid/ready interface. The results provide cycle-accurate activity reference values for cross-checking power-trace tooling.

---
 rtl/tristate_activity_monitor.sv | 164 ++++++++++++++++
 tb/tb_tristate_activity_monitor.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/tristate_activity_monitor.sv
// tristate_activity_monitor
//   Samples the output of a tristate driver stage every clock and accumulates
//   switching-activity statistics over fixed windows of WINDOW samples. Each
//   completed window is presented on a valid/ready result interface.
//
// Ports:
//   clk        - clock, all sampling on rising edge
//   rst_n      - asynchronous active-low reset
//   en         - monitoring enable; deasserting discards the partial window
//   line_in    - data output of the tristate stage
//   z_in       - high-Z indicator of the tristate stage (1 = not driven)
//   res_valid  - result available
//   res_ready  - consumer accepts result
//   toggle_cnt - driven-to-driven value changes in the window
//   z_cnt      - samples with z_in=1 in the window
//   zx_cnt     - z_in transitions (either direction) in the window
//   overflow   - some counter of this result saturated
//   dropped    - sticky: a completed window was discarded
module tristate_activity_monitor #(
  parameter int unsigned WINDOW = 16,
  parameter int unsigned CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             line_in,
  input  logic             z_in,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] toggle_cnt,
  output logic [CNT_W-1:0] z_cnt,
  output logic [CNT_W-1:0] zx_cnt,
  output logic             overflow,
  output logic             dropped
);

  localparam int unsigned IDX_W = $clog2(WINDOW);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WINDOW - 1);

  typedef enum logic {
    IDLE,
    COUNT
  } state_t;

  state_t state, state_nxt;

  logic [IDX_W-1:0] idx, idx_nxt;
  logic [CNT_W-1:0] tog_w, z_w, zx_w;
  logic [CNT_W-1:0] tog_nxt, z_nxt, zx_nxt;
  logic [CNT_W-1:0] tog_sum, z_sum, zx_sum;
  logic             ovf_w, ovf_nxt, ovf_sum;
  logic             prev_valid, prev_line, prev_z;
  logic             pv_nxt, pl_nxt, pz_nxt;
  logic             tog_inc, z_inc, zx_inc;
  logic             win_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    tog_nxt   = tog_w;
    z_nxt     = z_w;
    zx_nxt    = zx_w;
    ovf_nxt   = ovf_w;
    pv_nxt    = prev_valid;
    pl_nxt    = prev_line;
    pz_nxt    = prev_z;
    win_end   = 1'b0;

    case (state)
      IDLE:    if (en)  state_nxt = COUNT;
      COUNT:   if (!en) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // Counts for the sample on this edge, including it.
    tog_inc = prev_valid && !z_in && !prev_z && (line_in != prev_line);
    z_inc   = z_in;
    zx_inc  = prev_valid && (z_in != prev_z);

    tog_sum = (tog_inc && tog_w != '1) ? tog_w + CNT_W'(1) : tog_w;
    z_sum   = (z_inc   && z_w   != '1) ? z_w   + CNT_W'(1) : z_w;
    zx_sum  = (zx_inc  && zx_w  != '1) ? zx_w  + CNT_W'(1) : zx_w;
    ovf_sum = ovf_w | (tog_inc && tog_w == '1) | (z_inc && z_w == '1)
                    | (zx_inc && zx_w == '1);

    if (en) begin
      // prev_* carry across window boundaries; only leaving COUNT clears them.
      pv_nxt = 1'b1;
      pl_nxt = line_in;
      pz_nxt = z_in;
      if (idx == LAST_IDX) begin
        // Sums go to the result registers; working set restarts for sample 0.
        win_end = 1'b1;
        idx_nxt = '0;
        tog_nxt = '0;
        z_nxt   = '0;
        zx_nxt  = '0;
        ovf_nxt = 1'b0;
      end else begin
        idx_nxt = idx + IDX_W'(1);
        tog_nxt = tog_sum;
        z_nxt   = z_sum;
        zx_nxt  = zx_sum;
        ovf_nxt = ovf_sum;
      end
    end else if (state == COUNT) begin
      idx_nxt = '0;
      tog_nxt = '0;
      z_nxt   = '0;
      zx_nxt  = '0;
      ovf_nxt = 1'b0;
      pv_nxt  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= '0;
      tog_w      <= '0;
      z_w        <= '0;
      zx_w       <= '0;
      ovf_w      <= 1'b0;
      prev_valid <= 1'b0;
      prev_line  <= 1'b0;
      prev_z     <= 1'b0;
    end else begin
      idx        <= idx_nxt;
      tog_w      <= tog_nxt;
      z_w        <= z_nxt;
      zx_w       <= zx_nxt;
      ovf_w      <= ovf_nxt;
      prev_valid <= pv_nxt;
      prev_line  <= pl_nxt;
      prev_z     <= pz_nxt;
    end
  end

  // A window ending on the acceptance edge replaces the accepted result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid  <= 1'b0;
      toggle_cnt <= '0;
      z_cnt      <= '0;
      zx_cnt     <= '0;
      overflow   <= 1'b0;
      dropped    <= 1'b0;
    end else if (win_end && (!res_valid || res_ready)) begin
      res_valid  <= 1'b1;
      toggle_cnt <= tog_sum;
      z_cnt      <= z_sum;
      zx_cnt     <= zx_sum;
      overflow   <= ovf_sum;
    end else begin
      if (win_end)                dropped   <= 1'b1;
      if (res_valid && res_ready) res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tristate_activity_monitor.sv
// Directed bench for tristate_activity_monitor: one instance with 8-bit
// counters and one with 3-bit counters for saturation, both WINDOW=16.
module tb_tristate_activity_monitor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, line_in, z_in, res_ready;
  logic       res_valid, overflow, dropped;
  logic [7:0] toggle_cnt, z_cnt, zx_cnt;
  logic       s_valid, s_overflow, s_dropped;
  logic [2:0] s_toggle, s_z, s_zx;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tristate_activity_monitor #(.WINDOW(16), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .line_in(line_in), .z_in(z_in),
    .res_valid(res_valid), .res_ready(res_ready), .toggle_cnt(toggle_cnt),
    .z_cnt(z_cnt), .zx_cnt(zx_cnt), .overflow(overflow), .dropped(dropped)
  );

  tristate_activity_monitor #(.WINDOW(16), .CNT_W(3)) dut_s (
    .clk(clk), .rst_n(rst_n), .en(en), .line_in(line_in), .z_in(z_in),
    .res_valid(s_valid), .res_ready(res_ready), .toggle_cnt(s_toggle),
    .z_cnt(s_z), .zx_cnt(s_zx), .overflow(s_overflow), .dropped(s_dropped)
  );

  task automatic step(input logic e, input logic l, input logic z, input logic r);
    en = e; line_in = l; z_in = z; res_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    en = 1'b0; line_in = 1'b0; z_in = 1'b0; res_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({res_valid, toggle_cnt, z_cnt, zx_cnt, overflow, dropped} !== 27'd0) begin
      errors++;
      $display("FAIL reset_state: got v=%b t=%0d z=%0d zx=%0d o=%b d=%b required all 0",
               res_valid, toggle_cnt, z_cnt, zx_cnt, overflow, dropped);
    end
    // Build up a held result and a dropped window, then reset mid-window.
    for (int c = 0; c < 36; c++) step(1'b1, c[0], 1'b0, 1'b0);
    checks++;
    if ({res_valid, dropped} !== 2'b11) begin
      errors++;
      $display("FAIL reset_precond: got v=%b d=%b required v=1 d=1", res_valid, dropped);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({res_valid, toggle_cnt, z_cnt, zx_cnt, overflow, dropped} !== 27'd0) begin
      errors++;
      $display("FAIL reset_async: got v=%b t=%0d z=%0d zx=%0d o=%b d=%b required all 0",
               res_valid, toggle_cnt, z_cnt, zx_cnt, overflow, dropped);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_alternating();
    do_reset();
    for (int c = 0; c < 48; c++) begin
      step(1'b1, c[0], 1'b0, 1'b1);
      checks++;
      if (res_valid !== ((c % 16) == 15)) begin
        errors++;
        $display("FAIL alt_valid c=%0d: got %b required %b", c, res_valid, (c % 16) == 15);
      end
      if ((c % 16) == 15) begin
        checks++;
        if ({toggle_cnt, z_cnt, zx_cnt, overflow} !== {(c == 15) ? 8'd15 : 8'd16, 8'd0, 8'd0, 1'b0}) begin
          errors++;
          $display("FAIL alt_result c=%0d: got t=%0d z=%0d zx=%0d o=%b required t=%0d z=0 zx=0 o=0",
                   c, toggle_cnt, z_cnt, zx_cnt, overflow, (c == 15) ? 15 : 16);
        end
      end
    end
    checks++;
    if (dropped !== 1'b0) begin
      errors++;
      $display("FAIL alt_dropped: got %b required 0", dropped);
    end
  endtask

  task automatic test_z_pattern();
    do_reset();
    for (int c = 0; c < 32; c++) begin
      step(1'b1, 1'b1, c[1], 1'b1);
      if ((c % 16) == 15) begin
        checks++;
        if ({res_valid, toggle_cnt, z_cnt, zx_cnt} !== {1'b1, 8'd0, 8'd8, (c == 15) ? 8'd7 : 8'd8}) begin
          errors++;
          $display("FAIL zpat_result c=%0d: got v=%b t=%0d z=%0d zx=%0d required v=1 t=0 z=8 zx=%0d",
                   c, res_valid, toggle_cnt, z_cnt, zx_cnt, (c == 15) ? 7 : 8);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int c = 0; c < 48; c++) begin
      step(1'b1, c[0], 1'b0, c >= 40);
      if (c >= 15 && c < 40) begin
        checks++;
        if ({res_valid, toggle_cnt, z_cnt, zx_cnt, dropped} !== {1'b1, 8'd15, 8'd0, 8'd0, c >= 31}) begin
          errors++;
          $display("FAIL bp_hold c=%0d: got v=%b t=%0d z=%0d zx=%0d d=%b required v=1 t=15 z=0 zx=0 d=%b",
                   c, res_valid, toggle_cnt, z_cnt, zx_cnt, dropped, c >= 31);
        end
      end
      if (c == 40) begin
        checks++;
        if (res_valid !== 1'b0) begin
          errors++;
          $display("FAIL bp_accept: got v=%b required 0", res_valid);
        end
      end
      if (c == 47) begin
        checks++;
        if ({res_valid, toggle_cnt, z_cnt, zx_cnt, dropped} !== {1'b1, 8'd16, 8'd0, 8'd0, 1'b1}) begin
          errors++;
          $display("FAIL bp_next: got v=%b t=%0d z=%0d zx=%0d d=%b required v=1 t=16 z=0 zx=0 d=1",
                   res_valid, toggle_cnt, z_cnt, zx_cnt, dropped);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    // Acceptance coincides with the second window end.
    for (int c = 0; c < 32; c++) step(1'b1, c[0], 1'b0, c == 31);
    checks++;
    if ({res_valid, toggle_cnt, dropped} !== {1'b1, 8'd16, 1'b0}) begin
      errors++;
      $display("FAIL b2b_result: got v=%b t=%0d d=%b required v=1 t=16 d=0",
               res_valid, toggle_cnt, dropped);
    end
  endtask

  task automatic test_enable_abort();
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, i[0], 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (res_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_partial: got v=%b required 0", res_valid);
    end
    for (int i = 0; i < 16; i++) begin
      step(1'b1, i[0], 1'b0, 1'b1);
      checks++;
      if (res_valid !== (i == 15)) begin
        errors++;
        $display("FAIL abort_valid i=%0d: got %b required %b", i, res_valid, i == 15);
      end
    end
    checks++;
    if ({toggle_cnt, z_cnt, zx_cnt} !== {8'd15, 8'd0, 8'd0}) begin
      errors++;
      $display("FAIL abort_result: got t=%0d z=%0d zx=%0d required t=15 z=0 zx=0",
               toggle_cnt, z_cnt, zx_cnt);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int c = 0; c < 16; c++) step(1'b1, 1'b0, 1'b1, 1'b1);
    checks++;
    if ({s_valid, s_toggle, s_z, s_zx, s_overflow} !== {1'b1, 3'd0, 3'd7, 3'd0, 1'b1}) begin
      errors++;
      $display("FAIL sat_w1: got v=%b t=%0d z=%0d zx=%0d o=%b required v=1 t=0 z=7 zx=0 o=1",
               s_valid, s_toggle, s_z, s_zx, s_overflow);
    end
    checks++;
    if ({z_cnt, overflow} !== {8'd16, 1'b0}) begin
      errors++;
      $display("FAIL sat_wide: got z=%0d o=%b required z=16 o=0", z_cnt, overflow);
    end
    for (int c = 0; c < 16; c++) step(1'b1, 1'b1, 1'b0, 1'b1);
    checks++;
    if ({s_valid, s_toggle, s_z, s_zx, s_overflow, s_dropped} !== {1'b1, 3'd0, 3'd0, 3'd1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL sat_w2: got v=%b t=%0d z=%0d zx=%0d o=%b d=%b required v=1 t=0 z=0 zx=1 o=0 d=0",
               s_valid, s_toggle, s_z, s_zx, s_overflow, s_dropped);
    end
  endtask

  initial begin
    test_reset();
    test_alternating();
    test_z_pattern();
    test_backpressure();
    test_back_to_back();
    test_enable_abort();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
